// File: rtl/quantum_measurement_sampler_pkg.sv
// Shared constants, state encoding and LFSR step function for the 2-qubit measurement sampler.
`ifndef QUANTUM_MEASUREMENT_SAMPLER_PKG_SV
`define QUANTUM_MEASUREMENT_SAMPLER_PKG_SV
package quantum_measurement_sampler_pkg;
    // Magnitudes are signed S2.13: sign, INT_BITS integer, FX_BITS fraction.
    localparam int INT_BITS   = 2;
    localparam int FX_BITS    = 13;
    localparam int TOTAL_BITS = 1 + INT_BITS + FX_BITS;
    localparam int NUM_BASIS  = 4;
    localparam int CUM_W      = TOTAL_BITS + 2;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {IDLE, PREP, DRAW, EMIT, FIN} state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction
endpackage
`endif

// File: rtl/quantum_measurement_sampler_if.sv
// Request/outcome bundle between a driver and the measurement sampler.
interface quantum_measurement_sampler_if #(
    parameter int SHOT_W = 16,
    parameter int CNT_W  = 16
);
    import quantum_measurement_sampler_pkg::*;

    logic                      start;
    logic [TOTAL_BITS*4-1:0]   mag_sq_in;
    logic [SHOT_W-1:0]         num_shots;
    logic [15:0]               seed_in;
    logic                      seed_load;
    logic                      busy;
    logic                      shot_valid;
    logic [1:0]                shot_index;
    logic                      shot_ready;
    logic                      done;
    logic                      err_zero;
    logic [CNT_W*4-1:0]        counts;

    modport master (
        output start, mag_sq_in, num_shots, seed_in, seed_load, shot_ready,
        input  busy, shot_valid, shot_index, done, err_zero, counts
    );

    modport slave (
        input  start, mag_sq_in, num_shots, seed_in, seed_load, shot_ready,
        output busy, shot_valid, shot_index, done, err_zero, counts
    );
endinterface

// File: rtl/quantum_measurement_sampler_lfsr16_galois.sv
// 16-bit Galois LFSR with seed load; an all-zero seed is replaced by SEED so it never locks up.
module lfsr16_galois
    import quantum_measurement_sampler_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else if (load)
            state <= (seed == 16'd0) ? SEED : seed;
        else if (step)
            state <= lfsr_next(state);
    end
endmodule

// File: rtl/quantum_measurement_sampler.sv
// Draws basis-state outcomes from |amp|^2 weights with an LFSR and keeps a per-basis histogram.
module quantum_measurement_sampler
    import quantum_measurement_sampler_pkg::*;
#(
    parameter int          SHOT_W    = 16,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                         clk,
    input  logic                         rst_n,
    quantum_measurement_sampler_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    // Index 0 sits at the MSB so these line up with the packed bus ordering.
    logic [0:NUM_BASIS-1][TOTAL_BITS-1:0] mag_q;
    logic [0:NUM_BASIS-1][CNT_W-1:0]      hist;

    logic [NUM_BASIS-1:0][CUM_W-1:0] cum_d, cum_q;
    logic [CUM_W-1:0]                acc, mag_pos, r;
    logic [16+CUM_W-1:0]             prod;
    logic [SHOT_W-1:0]               shots_q, shot_cnt;
    logic [15:0]                     lfsr, lfsr_adv;
    logic [1:0]                      idx_d, idx_q;
    logic                            zero_prob, last_shot, lfsr_load, lfsr_step;

    assign lfsr_load = (state == IDLE) && bus.seed_load;
    assign lfsr_step = (state == DRAW);
    assign last_shot = (shot_cnt == shots_q - SHOT_W'(1));

    lfsr16_galois #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (bus.seed_in),
        .step  (lfsr_step),
        .state (lfsr)
    );

    // Negative magnitudes are numerical noise from upstream; treat them as zero weight.
    always_comb begin
        acc     = '0;
        mag_pos = '0;
        cum_d   = '0;
        for (int b = 0; b < NUM_BASIS; b++) begin
            mag_pos  = mag_q[b][TOTAL_BITS-1] ? '0 : CUM_W'(mag_q[b]);
            acc      = acc + mag_pos;
            cum_d[b] = acc;
        end
    end

    // Scale the freshly stepped LFSR into [0, c3); the smallest ci above it picks the basis.
    always_comb begin
        lfsr_adv = lfsr_next(lfsr);
        prod     = {{CUM_W{1'b0}}, lfsr_adv} * {16'd0, cum_q[NUM_BASIS-1]};
        r        = CUM_W'(prod >> 16);
        idx_d    = 2'(NUM_BASIS - 1);
        for (int i = NUM_BASIS - 2; i >= 0; i--)
            if (r < cum_q[i]) idx_d = 2'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = PREP;
            PREP: state_nxt = (shots_q == '0 || cum_d[NUM_BASIS-1] == '0) ? FIN : DRAW;
            DRAW: state_nxt = EMIT;
            EMIT: if (bus.shot_ready) state_nxt = last_shot ? FIN : DRAW;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.shot_valid = (state == EMIT);
        bus.done       = (state == FIN);
        bus.err_zero   = (state == FIN) && zero_prob && (shots_q != '0);
    end

    assign bus.shot_index = idx_q;
    assign bus.counts     = hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q     <= '0;
            shots_q   <= '0;
            shot_cnt  <= '0;
            cum_q     <= '0;
            idx_q     <= '0;
            zero_prob <= 1'b0;
            hist      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mag_q    <= bus.mag_sq_in;
                    shots_q  <= bus.num_shots;
                    shot_cnt <= '0;
                    hist     <= '0;
                end
                PREP: begin
                    cum_q     <= cum_d;
                    zero_prob <= (cum_d[NUM_BASIS-1] == '0);
                end
                DRAW: idx_q <= idx_d;
                EMIT: if (bus.shot_ready) begin
                    shot_cnt <= shot_cnt + SHOT_W'(1);
                    for (int b = 0; b < NUM_BASIS; b++)
                        if (idx_q == 2'(b) && hist[b] != CNT_MAX)
                            hist[b] <= hist[b] + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_quantum_measurement_sampler.sv
// Table of measurement runs checked shot-by-shot against a probability-draw reference model.
module tb_quantum_measurement_sampler;
    import quantum_measurement_sampler_pkg::*;

    localparam logic [15:0] SEED_DEF = 16'hACE1;
    localparam int          ONE      = 1 << FX_BITS;

    typedef struct {
        int          mag [4];
        int          shots;
        logic [15:0] seed;
        bit          load;
        int          rdy_mode;  // 0 ready held high, 1 random, 2 low for first 5 valid cycles
        bit          poke;      // try start/seed_load while busy
        bit          exp_err;
        int          exp_shots;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quantum_measurement_sampler_if #(.SHOT_W(16), .CNT_W(16)) bus ();

    quantum_measurement_sampler #(.SHOT_W(16), .CNT_W(16), .LFSR_SEED(SEED_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    int          m_cnt [4];
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // One shot: scale the uniform draw onto total weight, then walk the cumulative distribution.
    function automatic int pick(input int m [4], input logic [15:0] v);
        longint tot, run, r;
        tot = 0;
        for (int i = 0; i < 4; i++) tot += (m[i] > 0) ? m[i] : 0;
        r   = (longint'(v) * tot) >> 16;
        run = 0;
        for (int i = 0; i < 4; i++) begin
            run += (m[i] > 0) ? m[i] : 0;
            if (r < run) return i;
        end
        return -1;
    endfunction

    function automatic logic [63:0] m_counts();
        return {16'(m_cnt[0]), 16'(m_cnt[1]), 16'(m_cnt[2]), 16'(m_cnt[3])};
    endfunction

    function automatic vec_t mk(input int m0, input int m1, input int m2, input int m3,
                                input int shots, input logic [15:0] seed, input bit load,
                                input int mode, input bit poke, input bit err, input int exp_n);
        vec_t v;
        v.mag[0] = m0; v.mag[1] = m1; v.mag[2] = m2; v.mag[3] = m3;
        v.shots = shots; v.seed = seed; v.load = load; v.rdy_mode = mode;
        v.poke = poke; v.exp_err = err; v.exp_shots = exp_n;
        return v;
    endfunction

    function automatic bit ready_for(input int mode, input int stall);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return stall >= 5;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int       cyc, since_hs, emitted, stall, exp_idx;
        bit       prev_valid, prev_hs, got_done;
        logic [1:0] prev_idx;
        @(negedge clk);
        bus.mag_sq_in  = {TOTAL_BITS'(v.mag[0]), TOTAL_BITS'(v.mag[1]),
                          TOTAL_BITS'(v.mag[2]), TOTAL_BITS'(v.mag[3])};
        bus.num_shots  = 16'(v.shots);
        bus.seed_in    = v.seed;
        bus.seed_load  = v.load;
        bus.start      = 1'b1;
        bus.shot_ready = 1'b0;
        if (v.load) m_lfsr = (v.seed == 16'd0) ? SEED_DEF : v.seed;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        cyc = 0; since_hs = 100; emitted = 0; stall = 0;
        prev_valid = 0; prev_hs = 0; got_done = 0; prev_idx = '0;
        while (!got_done && cyc < 20000) begin
            @(negedge clk);
            cyc++; since_hs++;
            bus.start = 1'b0; bus.seed_load = 1'b0;
            if (v.poke && cyc == 4) begin
                bus.start = 1'b1; bus.seed_load = 1'b1; bus.seed_in = 16'h5555;
                bus.num_shots = 16'(v.shots + 5); bus.mag_sq_in = '0;
            end
            bus.shot_ready = ready_for(v.rdy_mode, stall);
            if (since_hs == 1) chk({tag, "_valid_gap_low"}, bus.shot_valid, 1'b0);
            if (bus.shot_valid) begin
                if (!prev_valid) begin
                    if (emitted == 0) chk({tag, "_first_latency"}, cyc, 3);
                    else              chk({tag, "_shot_gap"}, since_hs, 2);
                end else if (!prev_hs) begin
                    chk({tag, "_index_hold"}, bus.shot_index, prev_idx);
                end
                chk({tag, "_counts_live"}, bus.counts, m_counts());
                if (bus.shot_ready) begin
                    m_lfsr  = m_step(m_lfsr);
                    exp_idx = pick(v.mag, m_lfsr);
                    chk({tag, "_index"}, bus.shot_index, exp_idx);
                    if (exp_idx >= 0) m_cnt[exp_idx]++;
                    emitted++;
                    since_hs = 0;
                end else begin
                    stall++;
                end
            end else if (prev_valid && !prev_hs) begin
                chk({tag, "_valid_dropped"}, bus.shot_valid, 1'b1);
            end
            if (bus.done) begin
                got_done = 1;
                chk({tag, "_err_zero"}, bus.err_zero, v.exp_err);
                chk({tag, "_shots_emitted"}, emitted, v.exp_shots);
                if (emitted > 0) chk({tag, "_done_latency"}, since_hs, 1);
                else             chk({tag, "_done_latency"}, cyc, 2);
                chk({tag, "_counts_final"}, bus.counts, m_counts());
            end else if (bus.err_zero) begin
                chk({tag, "_err_without_done"}, bus.err_zero, 1'b0);
            end
            prev_valid = bus.shot_valid;
            prev_hs    = bus.shot_valid && bus.shot_ready;
            prev_idx   = bus.shot_index;
        end
        chk({tag, "_done_seen"}, got_done, 1'b1);
        bus.shot_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_after"}, bus.busy, 1'b0);
        chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
        chk({tag, "_counts_hold"}, bus.counts, m_counts());
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        int hs_seen, guard;
        bit done_seen;
        logic [15:0] c0, c2;

        vecs[0]  = mk(ONE, 0, 0, 0,                   100, 16'h0,    0, 0, 0, 0, 100);
        vecs[1]  = mk(ONE/2, 0, ONE/2, 0,             1000, 16'h0,   0, 1, 0, 0, 1000);
        vecs[2]  = mk(ONE/4, ONE/4, ONE/4, ONE/4,     4, 16'h1234,   1, 2, 0, 0, 4);
        vecs[3]  = mk(ONE/4, ONE/4, ONE/4, ONE/4,     4, 16'h1234,   1, 0, 0, 0, 4);
        vecs[4]  = mk(0, 0, 0, 0,                     10, 16'h0,     0, 0, 0, 1, 0);
        vecs[5]  = mk(-1, -100, -ONE, -5,             10, 16'h0,     0, 0, 0, 1, 0);
        vecs[6]  = mk(ONE, 0, 0, 0,                   0, 16'h0,      0, 0, 0, 0, 0);
        vecs[7]  = mk(ONE/4, ONE/2, 0, ONE/4,         3, 16'h0,      1, 1, 1, 0, 3);
        for (int k = 8; k < 12; k++) begin
            vecs[k] = mk(int'($urandom_range(0, 12288)) - 2048, int'($urandom_range(0, 12288)) - 2048,
                         int'($urandom_range(0, 12288)) - 2048, int'($urandom_range(0, 12288)) - 2048,
                         int'($urandom_range(1, 40)), 16'($urandom), 1'($urandom_range(0, 1)),
                         1, 0, 0, 0);
            tot = 0;
            for (int i = 0; i < 4; i++) tot += (vecs[k].mag[i] > 0) ? vecs[k].mag[i] : 0;
            vecs[k].exp_err   = (tot == 0);
            vecs[k].exp_shots = (tot == 0) ? 0 : vecs[k].shots;
        end

        bus.start = 1'b0; bus.mag_sq_in = '0; bus.num_shots = '0;
        bus.seed_in = '0; bus.seed_load = 1'b0; bus.shot_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_valid", bus.shot_valid, 1'b0);
        chk("reset_index", bus.shot_index, 2'd0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_err_zero", bus.err_zero, 1'b0);
        chk("reset_counts", bus.counts, 64'd0);
        rst_n  = 1'b1;
        m_lfsr = SEED_DEF;

        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
            if (k == 1) begin
                c0 = bus.counts[63:48];
                c2 = bus.counts[31:16];
                chk("vec1_basis0_spread", (c0 >= 450 && c0 <= 550), 1'b1);
                chk("vec1_basis2_spread", (c2 >= 450 && c2 <= 550), 1'b1);
                chk("vec1_sum", 32'(c0) + 32'(c2), 1000);
            end
        end

        // Abort a run with reset after three accepted shots.
        @(negedge clk);
        bus.mag_sq_in = {TOTAL_BITS'(ONE/4), TOTAL_BITS'(ONE/4), TOTAL_BITS'(ONE/4), TOTAL_BITS'(ONE/4)};
        bus.num_shots = 16'd10; bus.start = 1'b1; bus.shot_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hs_seen = 0; guard = 0;
        while (hs_seen < 3 && guard < 200) begin
            if (bus.shot_valid && bus.shot_ready) hs_seen++;
            @(negedge clk);
            guard++;
        end
        chk("abort_three_shots", hs_seen, 3);
        bus.shot_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_valid", bus.shot_valid, 1'b0);
        chk("abort_index", bus.shot_index, 2'd0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_err_zero", bus.err_zero, 1'b0);
        chk("abort_counts", bus.counts, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = SEED_DEF;
        done_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1;
        end
        chk("abort_no_done", done_seen, 1'b0);
        run_vec(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/quantum_measurement_sampler.md
# quantum_measurement_sampler

Consumer end of the `quantum_state_magnitudes` interface: takes the four packed magnitude-squared values of a 2-qubit state and performs repeated projective "measurements" with a pseudo-random source. It emits one basis-state index per shot over a valid/ready handshake and keeps a per-basis shot histogram. It sits downstream of `qft_2_qubit` → `quantum_state_magnitudes` and turns probabilities back into discrete outcomes.

## Interface
- `SHOT_W`, 16, width of shot-count request
- `CNT_W`, 16, width of each histogram counter
- `LFSR_SEED`, 16'hACE1, reset/default LFSR state; also substituted for an all-zero loaded seed
- `clk` input 1 system clock
- `rst_n` input 1 asynchronous active-low reset; single clock domain
- `start` input 1 begin a run; honoured only in IDLE
- `mag_sq_in` input `TOTAL_BITS*4` packed |00>(MSB)…|11>(LSB), each signed S`INT_BITS`.`FX_BITS`; sampled on accepted `start`
- `num_shots` input `SHOT_W` shots to draw; sampled on accepted `start`
- `seed_in` input 16 LFSR seed
- `seed_load` input 1 load `seed_in` into LFSR; honoured only in IDLE
- `busy` output 1 high in every state except IDLE
- `shot_valid` output 1 outcome available
- `shot_index` output 2 measured basis index (0=|00> … 3=|11>)
- `shot_ready` input 1 downstream accepts outcome
- `done` output 1 one-cycle pulse at end of run
- `err_zero` output 1 one-cycle pulse with `done` when total probability is zero
- `counts` output `CNT_W*4` packed histogram, |00> at MSB

## Operation
- States: IDLE, PREP, DRAW, EMIT, FIN.
- IDLE: `start`=1 → latch inputs, clear `counts`, go PREP. `start` in any other state ignored.
- PREP: clamp each negative magnitude to 0; build unsigned cumulative sums c0..c3, width `TOTAL_BITS`+2 (no overflow). If `num_shots`=0 or c3=0 → FIN; else → DRAW.
- DRAW: advance LFSR one step; r = (lfsr × c3) >> 16 (product width 16+`TOTAL_BITS`+2); index = smallest i with r < ci; → EMIT.
- EMIT: `shot_valid`=1, `shot_index` stable. On `shot_valid`&`shot_ready`: increment `counts[index]` (saturating at 2^`CNT_W`-1), increment shot counter; last shot → FIN, else → DRAW.
- FIN: `done`=1 for one cycle; `err_zero`=1 in same cycle iff c3=0 and `num_shots`≠0; → IDLE.
- `counts` hold their value after FIN until next accepted `start`.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400); never reaches 0. `seed_in`=0 loads `LFSR_SEED`. `seed_load` and `start` in the same IDLE cycle: seed loaded first, run uses new seed.
- Zero-probability bases never emitted (r < c3 always; equal cumulative sums skip the basis).

## Timing
- Reset (async assert, sync release): state IDLE, `busy`=0, `shot_valid`=0, `shot_index`=0, `done`=0, `err_zero`=0, `counts`=0, LFSR=`LFSR_SEED`.
- `start` sampled at edge 0 → PREP at edge 1 → DRAW at edge 2 → `shot_valid` high after edge 3.
- Handshake at edge k → next `shot_valid` high after edge k+2 (valid low one cycle between shots).
- Final handshake at edge k → `done` high after edge k+1, `busy` low after edge k+2.
- Zero-shot / zero-probability run: `done` high after edge 2, no `shot_valid`.
- `shot_valid` never drops without a handshake; `shot_index` constant while valid.
- Reset mid-run aborts immediately; no `done` pulse.

## Structure
- Shared include: state encoding localparams, LFSR polynomial mask, default seed; fixed-point widths from existing `TOTAL_BITS`/`FX_BITS`/`INT_BITS` macros in `fixed_complex_utils.v`.
- One sub-module: `lfsr16_galois` (clk, rst_n, load, seed, step, state).
- Include guard consistent with other blocks.

## Test plan
- mag_sq = {1.0,0,0,0}, num_shots=100, ready=1 → 100 shots all index 0; counts={100,0,0,0}; one `done`.
- mag_sq = {0.5,0,0.5,0}, num_shots=1000 → only indices 0 and 2; each count within 450..550; sum 1000.
- mag_sq = {0.25,0.25,0.25,0.25}, seed 16'h1234, 4 shots, ready held low 5 cycles on first shot → valid/index stable, counts unchanged until ready; final sum 4; same seed rerun gives identical sequence.
- mag_sq all 0 (and one case with all negative), num_shots=10 → no `shot_valid`; `done`+`err_zero` pulse 2 cycles after start.
- num_shots=0 → `done` without `err_zero`, counts=0; `start` while busy ignored.
- Assert `rst_n` low mid-run after 3 shots → all outputs at reset values immediately; new run afterwards behaves as first case.
